// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with a registered one-hot grant and
// a hold watchdog that revokes a grant after TIMEOUT cycles without a release.
//
// Parameters:
//   TIMEOUT  maximum grant hold time in cycles without done (0 disables, 0..65535)
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      request vector, bit i = requester i wants the resource
//   done     release strobe from the current holder (ignored while idle)
//   gnt      registered grant, one-hot or zero
//   gnt_id   binary index of the granted requester, 0 when no grant
//   busy     high while a grant is held
//   timeout  one-cycle pulse when the watchdog revokes a grant
module rr_arbiter16 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned N_REQ   = 16;
  localparam int unsigned WD_W    = 16;
  localparam logic        ST_IDLE = 1'b0;
  localparam logic        ST_BUSY = 1'b1;

  // Watchdog enable and terminal count; the limit is unused when disabled.
  localparam logic            WD_EN    = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX   = '1;

  logic            state_q,   state_d;
  logic [15:0]     gnt_q,     gnt_d;
  logic [3:0]      gnt_id_q,  gnt_id_d;
  logic            busy_q,    busy_d;
  logic            timeout_q, timeout_d;
  logic [3:0]      ptr_q,     ptr_d;
  logic [WD_W-1:0] wdog_q,    wdog_d;

  logic            win_found;
  logic [3:0]      win_id;
  logic [3:0]      scan_idx;

  // Round-robin search: first set req bit starting at ptr+1, wrapping through ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = ptr_q + 4'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    wdog_d    = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_BUSY;
          gnt_d    = 16'(1) << win_id;
          gnt_id_d = win_id;
          busy_d   = 1'b1;
          ptr_d    = win_id;
          wdog_d   = '0;
        end
      end
      ST_BUSY: begin
        if (done) begin
          // Release hands over directly when someone is waiting; no bubble.
          if (win_found) begin
            gnt_d    = 16'(1) << win_id;
            gnt_id_d = win_id;
            ptr_d    = win_id;
            wdog_d   = '0;
          end else begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            wdog_d   = '0;
          end
        end else if (WD_EN && (wdog_q == WD_LIMIT)) begin
          // Revoke; ptr stays on the revoked index so it loses priority next time.
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_id_d  = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          wdog_d    = '0;
        end else if (wdog_q != WD_MAX) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
        wdog_d   = '0;
      end
    endcase
  end

  // State registers; ptr resets to 15 so the first search begins at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 4'd15;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      wdog_q    <= wdog_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter16.md
RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a grant is held without done; 0 disables the watchdog; legal range 0..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port req, input, 16 bits: request vector; bit i set means requester i wants the shared resource.
REQ-005 The block SHALL have port done, input, 1 bit: release strobe from the current holder; sampled only while busy.
REQ-006 The block SHALL have port gnt, output, 16 bits: registered grant, one-hot or all-zero.
REQ-007 The block SHALL have port gnt_id, output, 4 bits: binary index of the set bit of gnt; 0 when gnt is zero.
REQ-008 The block SHALL have port busy, output, 1 bit: high exactly when gnt is non-zero.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse marking a watchdog revocation.

Function
REQ-010 The block SHALL implement two states: IDLE (no grant) and BUSY (one grant held).
REQ-011 The block SHALL keep an internal 4-bit pointer ptr holding the index of the most recent grant.
REQ-012 Arbitration SHALL select the first set bit of req, searching upward from index ptr+1 mod 16 and wrapping through index ptr, so the last holder has lowest priority.
REQ-013 In IDLE with req nonzero, the next edge SHALL load gnt = onehot(winner), gnt_id = winner, busy = 1, ptr = winner, clear the watchdog, and enter BUSY; grant latency is one cycle from request sampling.
REQ-014 In IDLE with req zero, all outputs SHALL remain zero and ptr SHALL be unchanged.
REQ-015 The done input SHALL be ignored in IDLE.
REQ-016 In BUSY, gnt, gnt_id and ptr SHALL hold regardless of req changes, including the holder dropping its req bit, until done or timeout.
REQ-017 In BUSY with done = 1, the next edge SHALL re-arbitrate per REQ-012 using the current req.
REQ-018 If that re-arbitration finds a winner, the block SHALL grant it directly and stay in BUSY, with no bubble cycle.
REQ-019 If req is zero at that point, the block SHALL clear gnt, gnt_id and busy and enter IDLE.
REQ-020 The watchdog SHALL be a 16-bit counter cleared on every new grant and incremented each BUSY cycle with done = 0.
REQ-021 With TIMEOUT > 0, when the counter equals TIMEOUT-1 and done = 0, the next edge SHALL clear gnt, gnt_id and busy, assert timeout for exactly one cycle, enter IDLE, and leave ptr at the revoked index; a grant is therefore held at most TIMEOUT cycles.
REQ-022 After a timeout, the block SHALL spend at least one cycle in IDLE before any new grant.
REQ-023 When done and the timeout condition coincide, done SHALL take precedence and timeout SHALL stay 0.
REQ-024 The counter SHALL saturate and never wrap; with TIMEOUT = 0, timeout SHALL never assert.
REQ-025 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-026 While rst = 1 at a clock edge, the block SHALL set state IDLE, gnt = 16'h0000, gnt_id = 0, busy = 0, timeout = 0, watchdog = 0, and ptr = 15, so that the first search starts at index 0.
REQ-027 Reset SHALL override done, req and the watchdog in the same cycle, including reset asserted mid-grant.

Verification
REQ-028 Scenario: after reset, req = 16'h0001 -> one cycle later gnt = 16'h0001, gnt_id = 0, busy = 1.
REQ-029 Scenario: req = 16'hFFFF held, done pulsed in every BUSY cycle -> gnt_id sequence 0,1,2,...,15,0 with busy continuously 1.
REQ-030 Scenario: holder 5 pulses done while req = 16'h0021 -> next gnt_id = 0 (wrap), then after done -> gnt_id = 5.
REQ-031 Scenario: TIMEOUT = 4, req = 16'h0008, done never asserted -> gnt = 16'h0008 for 4 cycles, then gnt = 0 with timeout = 1 for one cycle, then regrant of id 3 on the following edge.
REQ-032 Scenario: TIMEOUT = 4, done asserted in the 4th grant cycle -> timeout stays 0 and the grant releases or passes on normally.
REQ-033 Scenario: rst pulsed while busy with gnt_id = 9 -> next cycle all outputs 0; then req = 16'h8001 -> gnt_id = 0.
